ecg_peak_detector: RTL and testbench

Downstream stage of the ECG waveform generator. Consumes the signed 16-bit ECG sample stream and detects R-peaks with an adaptive amplitude threshold and a refractory window. For each detected beat it reports the peak amplitude and the R-R interval measured in samples. Its results feed the heart-rate display and alarm logic.

---
 rtl/ecg_peak_detector.sv | 146 ++++++++++++++
 tb/tb_ecg_peak_detector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_peak_detector.sv
// ecg_peak_detector: R-peak detection with a refractory window and R-R interval measurement.
// Optional feature macro ECG_PEAK_ADAPT_EN enables threshold decay and reload; without it the threshold is fixed.
module ecg_peak_detector #(
    parameter int                        DATA_W      = 16,
    parameter int                        RR_W        = 16,
    parameter int                        REFRACT     = 64,
    parameter logic signed [DATA_W-1:0]  INIT_THRESH = 16'sh1000,
    parameter logic signed [DATA_W-1:0]  MIN_THRESH  = 16'sh0400,
    parameter int                        DECAY_SHIFT = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     beat,
    output logic signed [DATA_W-1:0] peak_value,
    output logic [RR_W-1:0]          rr_interval,
    output logic                     rr_valid,
    output logic signed [DATA_W-1:0] threshold
);

    // A zero-length refractory window still needs one sample to leave REFRACTORY.
    localparam int REF_LOAD = (REFRACT < 1) ? 1 : REFRACT;
    localparam int CNT_W    = $clog2(REF_LOAD + 1);

    typedef enum logic [1:0] {
        SEARCH     = 2'd0,
        RISING     = 2'd1,
        REFRACTORY = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic signed [DATA_W-1:0]   cand;
    logic signed [DATA_W-1:0]   cand_next;
    logic [CNT_W-1:0]           ref_cnt;
    logic [CNT_W-1:0]           ref_cnt_next;
    logic [RR_W-1:0]            rr_cnt;
    logic                       seen_beat;
    logic                       confirm;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEARCH;
        end else if (sample_valid) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cand_next    = cand;
        ref_cnt_next = ref_cnt;
        confirm      = 1'b0;
        case (state)
            SEARCH: begin
                if (sample_in > threshold) begin
                    cand_next  = sample_in;
                    state_next = RISING;
                end
            end
            RISING: begin
                // Plateaus stay here; only a strictly smaller sample confirms the peak.
                if (sample_in >= cand) begin
                    cand_next = sample_in;
                end else begin
                    confirm      = 1'b1;
                    ref_cnt_next = CNT_W'(REF_LOAD);
                    state_next   = REFRACTORY;
                end
            end
            REFRACTORY: begin
                ref_cnt_next = ref_cnt - CNT_W'(1);
                if (ref_cnt == CNT_W'(1)) begin
                    state_next = SEARCH;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cand        <= '0;
            ref_cnt     <= '0;
            rr_cnt      <= '0;
            seen_beat   <= 1'b0;
            beat        <= 1'b0;
            rr_valid    <= 1'b0;
            peak_value  <= '0;
            rr_interval <= '0;
        end else begin
            beat     <= 1'b0;
            rr_valid <= 1'b0;
            if (sample_valid) begin
                cand    <= cand_next;
                ref_cnt <= ref_cnt_next;
                // The first beat has no predecessor, so it reports no interval.
                if (confirm) begin
                    beat       <= 1'b1;
                    peak_value <= cand;
                    seen_beat  <= 1'b1;
                    rr_cnt     <= RR_W'(1);
                    if (seen_beat) begin
                        rr_interval <= rr_cnt;
                        rr_valid    <= 1'b1;
                    end
                end else if (rr_cnt != {RR_W{1'b1}}) begin
                    rr_cnt <= rr_cnt + RR_W'(1);
                end
            end
        end
    end

`ifdef ECG_PEAK_ADAPT_EN
    logic signed [DATA_W-1:0] thresh_reg;
    logic signed [DATA_W-1:0] decayed;
    logic signed [DATA_W-1:0] reloaded;

    assign decayed  = thresh_reg - (thresh_reg >>> DECAY_SHIFT);
    assign reloaded = cand >>> 1;

    // Reload to half the confirmed peak on each beat, otherwise decay slowly while searching.
    always_ff @(posedge clk) begin
        if (!reset) begin
            thresh_reg <= INIT_THRESH;
        end else if (sample_valid) begin
            if (confirm) begin
                thresh_reg <= (reloaded < MIN_THRESH) ? MIN_THRESH : reloaded;
            end else if ((state == SEARCH) && !(sample_in > thresh_reg)) begin
                thresh_reg <= (decayed < MIN_THRESH) ? MIN_THRESH : decayed;
            end
        end
    end

    assign threshold = thresh_reg;
`else
    logic unused_adapt_cfg;

    assign threshold        = INIT_THRESH;
    assign unused_adapt_cfg = ^{MIN_THRESH, 8'(DECAY_SHIFT)};
`endif

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Scoreboard bench for ecg_peak_detector: a spec-level model predicts every cycle's outputs.
// Builds with or without ECG_PEAK_ADAPT_EN; a second instance uses RR_W=8 to exercise saturation.
module tb_ecg_peak_detector;

    localparam int          REFRACT     = 64;
    localparam logic [15:0] INIT_THRESH = 16'h1000;
    localparam logic [15:0] MIN_THRESH  = 16'h0400;
`ifdef ECG_PEAK_ADAPT_EN
    localparam logic [15:0] T2_THRESH   = 16'h1800;
`else
    localparam logic [15:0] T2_THRESH   = 16'h1000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        beat;
    logic [15:0] peak_value;
    logic [15:0] rr_interval;
    logic        rr_valid;
    logic [15:0] threshold;
    logic        beat8;
    logic [15:0] peak_value8;
    logic [7:0]  rr_interval8;
    logic        rr_valid8;
    logic [15:0] threshold8;

    ecg_peak_detector dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .beat         (beat),
        .peak_value   (peak_value),
        .rr_interval  (rr_interval),
        .rr_valid     (rr_valid),
        .threshold    (threshold)
    );

    ecg_peak_detector #(.RR_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .beat         (beat8),
        .peak_value   (peak_value8),
        .rr_interval  (rr_interval8),
        .rr_valid     (rr_valid8),
        .threshold    (threshold8)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          beat;
        bit          rrv;
        logic [15:0] peak;
        logic [15:0] rr;
        logic [15:0] thr;
        logic [7:0]  rr8;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int                 m_state;
    logic signed [15:0] m_cand;
    logic signed [15:0] m_thr;
    logic [15:0]        m_peak;
    logic [15:0]        m_rr;
    int                 m_rrcnt;
    int                 m_cnt;
    bit                 m_seen;
    bit                 m_beat;
    bit                 m_rrv;

    // Values captured from the DUT on beats, for the scenario-level checks
    int          beat_count;
    logic [15:0] cap_peak;
    logic [15:0] cap_rr;
    logic [15:0] cap_thr;
    bit          cap_rrv;
    logic [7:0]  cap_rr8;
    bit          cap_rrv8;
    bit          thr_moved;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst_n, input bit valid, input logic signed [15:0] s);
        bit confirm;
        logic signed [15:0] t;
        if (!rst_n) begin
            m_state = 0; m_cand = '0; m_thr = INIT_THRESH; m_peak = '0; m_rr = '0;
            m_rrcnt = 0; m_cnt = 0; m_seen = 0; m_beat = 0; m_rrv = 0;
            return;
        end
        m_beat = 0;
        m_rrv  = 0;
        if (!valid) return;
        confirm = 0;
        case (m_state)
            0: begin
                if (s > m_thr) begin
                    m_cand = s;
                    m_state = 1;
                end else begin
`ifdef ECG_PEAK_ADAPT_EN
                    t = m_thr - (m_thr >>> 6);
                    m_thr = (t < $signed(MIN_THRESH)) ? $signed(MIN_THRESH) : t;
`endif
                end
            end
            1: begin
                if (s >= m_cand) begin
                    m_cand = s;
                end else begin
                    confirm = 1;
                    m_beat = 1;
                    m_peak = m_cand;
                    m_cnt = REFRACT;
                    m_state = 2;
`ifdef ECG_PEAK_ADAPT_EN
                    t = m_cand >>> 1;
                    m_thr = (t < $signed(MIN_THRESH)) ? $signed(MIN_THRESH) : t;
`endif
                end
            end
            default: begin
                if (m_cnt == 1) m_state = 0;
                m_cnt--;
            end
        endcase
        if (confirm) begin
            if (m_seen) begin
                m_rr = 16'(m_rrcnt);
                m_rrv = 1;
            end
            m_seen = 1;
            m_rrcnt = 1;
        end else if (m_rrcnt < 65535) begin
            m_rrcnt++;
        end
    endtask

    task automatic applyStimulus(input bit rst_n, input bit valid, input logic [15:0] s);
        exp_t e;
        @(negedge clk);
        reset        = rst_n;
        sample_valid = valid;
        sample_in    = s;
        modelStep(rst_n, valid, $signed(s));
        e.beat = m_beat;
        e.rrv  = m_rrv;
        e.peak = m_peak;
        e.rr   = m_rr;
        e.thr  = m_thr;
        e.rr8  = (m_rr > 16'd255) ? 8'd255 : m_rr[7:0];
        sb.push_back(e);
    endtask

    // Compare each cycle's outputs one step after the edge that produced them.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("beat", beat, e.beat);
            checkOutput("rr_valid", rr_valid, e.rrv);
            checkOutput("peak_value", peak_value, e.peak);
            checkOutput("rr_interval", rr_interval, e.rr);
            checkOutput("threshold", threshold, e.thr);
            checkOutput("beat8", beat8, e.beat);
            checkOutput("rr_valid8", rr_valid8, e.rrv);
            checkOutput("rr_interval8", rr_interval8, e.rr8);
            if (threshold !== INIT_THRESH) thr_moved = 1;
            if (beat) begin
                beat_count++;
                cap_peak = peak_value;
                cap_rr   = rr_interval;
                cap_rrv  = rr_valid;
                cap_thr  = threshold;
            end
            if (beat8) begin
                cap_rr8  = rr_interval8;
                cap_rrv8 = rr_valid8;
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic clearCapture();
        beat_count = 0; cap_peak = '0; cap_rr = '0; cap_thr = '0;
        cap_rrv = 0; cap_rr8 = '0; cap_rrv8 = 0; thr_moved = 0;
    endtask

    task automatic doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'h3000);
        settle();
        clearCapture();
    endtask

    task automatic genTrace(input int n, input int p1, input logic [15:0] v1, input int p2,
                            input logic [15:0] v2, input int p3, input logic [15:0] v3, input bit gaps);
        logic [15:0] s;
        for (int i = 0; i < n; i++) begin
            s = (i == p1) ? v1 : (i == p2) ? v2 : (i == p3) ? v3 : 16'h0000;
            applyStimulus(1, 1, s);
            if (gaps) applyStimulus(1, 0, 16'h7fff);
        end
        settle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearCapture();

        doReset();
        checkOutput("rst_beat", beat, 0);
        checkOutput("rst_rr_valid", rr_valid, 0);
        checkOutput("rst_rr_interval", rr_interval, 0);
        checkOutput("rst_threshold", threshold, INIT_THRESH);

        // Single excursion 0, 0x2000, 0x3000, 0x2800
        applyStimulus(1, 1, 16'h0000);
        applyStimulus(1, 1, 16'h2000);
        applyStimulus(1, 1, 16'h3000);
        applyStimulus(1, 1, 16'h2800);
        genTrace(70, -1, 0, -1, 0, -1, 0, 0);
        checkOutput("t2_beats", beat_count, 1);
        checkOutput("t2_peak", cap_peak, 16'h3000);
        checkOutput("t2_rr_valid", cap_rrv, 0);
        checkOutput("t2_threshold", cap_thr, T2_THRESH);

        // Reset while RISING discards the candidate
        doReset();
        applyStimulus(1, 1, 16'h0000);
        applyStimulus(1, 1, 16'h3000);
        applyStimulus(0, 1, 16'h0000);
        genTrace(80, -1, 0, -1, 0, -1, 0, 0);
        checkOutput("midrise_beats", beat_count, 0);

        // Peaks 100 samples apart, without and with idle gaps
        for (int g = 0; g < 2; g++) begin
            doReset();
            genTrace(130, 10, 16'h3000, 110, 16'h3000, -1, 0, bit'(g));
            checkOutput("rr_beats", beat_count, 2);
            checkOutput("rr_interval100", cap_rr, 100);
            checkOutput("rr_valid2", cap_rrv, 1);
        end

        // Excursion during the refractory window is ignored
        doReset();
        genTrace(110, 5, 16'h3000, 9, 16'h7000, 90, 16'h3000, 0);
        checkOutput("refr_beats", beat_count, 2);
        checkOutput("refr_peak", cap_peak, 16'h3000);
        checkOutput("refr_rr", cap_rr, 85);

        // 300-sample interval saturates the 8-bit instance
        doReset();
        genTrace(330, 10, 16'h3000, 310, 16'h3000, -1, 0, 0);
        checkOutput("sat_rr8", cap_rr8, 255);
        checkOutput("sat_rrv8", cap_rrv8, 1);
        checkOutput("sat_rr16", cap_rr, 300);

        // Smaller 0x1200 peak in the following search window
        doReset();
        genTrace(120, 10, 16'h3000, 100, 16'h1200, -1, 0, 0);
        checkOutput("small_beats", beat_count, 2);
        checkOutput("small_peak", cap_peak, 16'h1200);
`ifndef ECG_PEAK_ADAPT_EN
        checkOutput("thr_fixed", thr_moved, 0);
`endif

        checkOutput("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
